barrel_shift_pipe: RTL and testbench
====================================

Name: barrel_shift_pipe

Overview:
- Parametrised, pipelined successor to the 16-bit combinational left barrel shifter, for the ALU shift path.
- Adds four shift modes: logical left, logical right, arithmetic right and rotate left.
- Adds carry and zero flags, with one register stage per shift level.
- Uses a valid/ready handshake on input and output. It sustains one operation per cycle and supports full backpressure.

Parameters:
- WIDTH, 16, data width. Must be a power of two, at least 4.
- LEVELS, log2(WIDTH), derived localparam, not overridable. It is the shift-amount width and the pipeline depth.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  an operation is presented.
- in_ready  output  1  the block accepts the operation this cycle.
- in_data  input  WIDTH  operand.
- in_amt  input  LEVELS  shift amount, 0..WIDTH-1.
- in_mode  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROL.
- out_valid  output  1  a result is presented.
- out_ready  input  1  the consumer takes the result this cycle.
- out_data  output  WIDTH  result.
- out_carry  output  1  last bit shifted out, defined under Behaviour.
- out_zero  output  1  out_data equals 0.

Behaviour:
- Handshake:
  - A transfer occurs on any edge where valid and ready are both high.
  - in_valid and its payload are held until accepted.
  - out_data, out_carry and out_zero are stable while out_valid=1 and out_ready=0.
- Pipeline structure:
  - LEVELS stages; stage k (k=0..LEVELS-1) shifts by 2^k when amt bit k = 1.
  - Each stage registers valid, data, remaining amt, mode and carry.
  - Stage LEVELS-1 drives the out_* ports.
  - out_zero is computed from the final-stage data register, combinationally or registered alongside it.
- Flow control:
  - Stage i may load when it is empty or its contents move on this cycle.
  - The last stage moves on when out_ready=1.
  - in_ready = stage 0 may load. This is combinational from out_ready through the stage valids.
  - Bubbles collapse: a stalled output does not prevent upstream empty stages from filling.
- Latency and throughput:
  - With no backpressure, an operation accepted at edge N appears with out_valid=1 after edge N+LEVELS-1. That is LEVELS cycles, 4 for WIDTH=16.
  - Sustained throughput is 1 operation per cycle.
  - Capacity under a full stall is LEVELS operations. Order is always preserved; nothing is dropped or duplicated.
- Shift rules per stage, with s = 2^k:
  - LSL: zero-fill from bit 0.
  - LSR: zero-fill from the MSB.
  - ASR: fill with the operand's original sign bit (the MSB before any shift).
  - ROL: bits leaving the MSB re-enter at bit 0.
- Carry:
  - Starts at 0.
  - An active stage in LSL sets carry to pre-stage bit WIDTH-s.
  - An active stage in LSR or ASR sets carry to pre-stage bit s-1.
  - An inactive stage passes carry through.
  - Net result: LSL carry = in[WIDTH-amt]; LSR/ASR carry = in[amt-1].
  - ROL: carry = out_data[0] if amt != 0.
  - All modes: carry = 0 when amt = 0.
- Amount 0: data passes unchanged in every mode, carry=0, same latency.
- Reset:
  - While rst=1, all stage valids are cleared and all data, carry and amt registers go to 0.
  - Resulting output values: out_valid=0, out_data=0, out_carry=0, out_zero=1.
  - in_ready=1 after reset deasserts.
  - Reset mid-operation discards all in-flight operations; there is no partial output.
- Simultaneous accept and emit in the same cycle is legal; occupancy stays unchanged.

Test Plan:
- LSL 0x8001 amt=1, out_ready=1 -> 0x0002 with carry=1, zero=0, exactly 4 cycles after acceptance.
- Single-bit right shifts:
  - LSR 0x8001 amt=1 -> 0x4000, carry=1.
  - ASR 0x8000 amt=4 -> 0xF800, carry=0.
  - ASR 0x8008 amt=4 -> 0xF800, carry=1.
- ROL 0x8001 amt=4 -> 0x0018, carry=0. ROL 0x1234 amt=0 -> 0x1234, carry=0.
- LSL 0x8000 amt=1 -> 0x0000, carry=1, zero=1.
- Stall and drain:
  - Stimulus: back-to-back stream of 8 operations; out_ready=0 for 10 cycles, then 1.
  - Required: in_ready drops after 4 accepts; all 8 results emerge in order, with no loss or duplicates.
  - Required: out_* stay stable throughout the stall.
- Reset during the stream:
  - Stimulus: assert rst asynchronously with 3 operations in flight.
  - Required: out_valid=0 immediately; none of the 3 results ever appear.
  - Required: the next accepted operation returns correctly after 4 cycles.

Source files
------------

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter for the ALU shift path.
// Supports LSL, LSR, ASR and ROL, with carry and zero flags.
// There is one register stage per shift level, and a valid/ready handshake
// runs at both ends. Stalls backpressure through every stage, and empty
// stages (bubbles) collapse so upstream work keeps filling them.

module barrel_shift_stage #(
    parameter int WIDTH  = 16,
    parameter int LEVELS = 4,
    parameter int K      = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              vld_i,
    input  logic [WIDTH-1:0]  data_i,
    input  logic [LEVELS-1:0] amt_i,
    input  logic [1:0]        mode_i,
    input  logic              carry_i,
    output logic              vld_o,
    output logic [WIDTH-1:0]  data_o,
    output logic [LEVELS-1:0] amt_o,
    output logic [1:0]        mode_o,
    output logic              carry_o
);
    localparam int S = 1 << K;

    logic             vld_q;
    logic [WIDTH-1:0] data_q, data_d;
    logic [LEVELS-1:0] amt_q;
    logic [1:0]       mode_q;
    logic             carry_q, carry_d;

    // Shift by S when this level's amount bit is set; otherwise pass through.
    // ASR takes its fill from the current MSB. Earlier arithmetic stages keep
    // that MSB equal to the operand's original sign bit.
    always_comb begin
        data_d  = data_i;
        carry_d = carry_i;
        if (amt_i[K]) begin
            case (mode_i)
                2'b00: begin
                    data_d  = {data_i[WIDTH-S-1:0], {S{1'b0}}};
                    carry_d = data_i[WIDTH-S];
                end
                2'b01: begin
                    data_d  = {{S{1'b0}}, data_i[WIDTH-1:S]};
                    carry_d = data_i[S-1];
                end
                2'b10: begin
                    data_d  = {{S{data_i[WIDTH-1]}}, data_i[WIDTH-1:S]};
                    carry_d = data_i[S-1];
                end
                default: begin
                    data_d  = {data_i[WIDTH-S-1:0], data_i[WIDTH-1:WIDTH-S]};
                    carry_d = data_i[WIDTH-S];
                end
            endcase
        end
    end

    // Stage register. It only advances when the flow control lets it load,
    // so a stalled stage holds its contents unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q   <= 1'b0;
            data_q  <= '0;
            amt_q   <= '0;
            mode_q  <= 2'b00;
            carry_q <= 1'b0;
        end else if (load_i) begin
            vld_q   <= vld_i;
            data_q  <= data_d;
            amt_q   <= amt_i;
            mode_q  <= mode_i;
            carry_q <= carry_d;
        end
    end

    assign vld_o   = vld_q;
    assign data_o  = data_q;
    assign amt_o   = amt_q;
    assign mode_o  = mode_q;
    assign carry_o = carry_q;
endmodule

module barrel_shift_pipe #(
    parameter  int WIDTH  = 16,
    localparam int LEVELS = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [LEVELS-1:0] in_amt,
    input  logic [1:0]        in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_carry,
    output logic              out_zero
);
    logic [LEVELS-1:0]                  load;
    logic [LEVELS-1:0]                  stg_vld,   src_vld;
    logic [LEVELS-1:0][WIDTH-1:0]       stg_data,  src_data;
    logic [LEVELS-1:0][LEVELS-1:0]      stg_amt,   src_amt;
    logic [LEVELS-1:0][1:0]             stg_mode,  src_mode;
    logic [LEVELS-1:0]                  stg_carry, src_carry;

    // A stage may load when it is empty or when the stage after it is taking
    // its contents. The last stage drains on out_ready.
    always_comb begin
        load = '0;
        load[LEVELS-1] = !stg_vld[LEVELS-1] || out_ready;
        for (int k = LEVELS - 2; k >= 0; k--)
            load[k] = !stg_vld[k] || load[k+1];
    end

    // Stage inputs. Stage 0 is fed from the ports, and each later stage is
    // fed from the stage before it. Carry always enters the chain at 0.
    always_comb begin
        src_vld[0]   = in_valid;
        src_data[0]  = in_data;
        src_amt[0]   = in_amt;
        src_mode[0]  = in_mode;
        src_carry[0] = 1'b0;
        for (int k = 1; k < LEVELS; k++) begin
            src_vld[k]   = stg_vld[k-1];
            src_data[k]  = stg_data[k-1];
            src_amt[k]   = stg_amt[k-1];
            src_mode[k]  = stg_mode[k-1];
            src_carry[k] = stg_carry[k-1];
        end
    end

    for (genvar k = 0; k < LEVELS; k++) begin : g_stage
        barrel_shift_stage #(.WIDTH(WIDTH), .LEVELS(LEVELS), .K(k)) u_stage (
            .clk     (clk),
            .rst     (rst),
            .load_i  (load[k]),
            .vld_i   (src_vld[k]),
            .data_i  (src_data[k]),
            .amt_i   (src_amt[k]),
            .mode_i  (src_mode[k]),
            .carry_i (src_carry[k]),
            .vld_o   (stg_vld[k]),
            .data_o  (stg_data[k]),
            .amt_o   (stg_amt[k]),
            .mode_o  (stg_mode[k]),
            .carry_o (stg_carry[k])
        );
    end

    assign in_ready  = load[0];
    assign out_valid = stg_vld[LEVELS-1];
    assign out_data  = stg_data[LEVELS-1];
    assign out_carry = stg_carry[LEVELS-1];
    assign out_zero  = (stg_data[LEVELS-1] == '0);
endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Directed bench for barrel_shift_pipe (WIDTH=16).
// Covers reset values, every shift mode, the amount boundaries, stall and
// drain, and reset with operations in flight.

module tb_barrel_shift_pipe;
    localparam logic [1:0] LSL = 2'b00;
    localparam logic [1:0] LSR = 2'b01;
    localparam logic [1:0] ASR = 2'b10;
    localparam logic [1:0] ROL = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_amt;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_carry;
    logic        out_zero;

    int tests = 0;
    int fails = 0;

    barrel_shift_pipe #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; in_mode = LSL; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b want 0", out_valid); end
        tests++; if (out_data !== 16'h0000) begin fails++; $display("FAIL rst_data got %h want 0000", out_data); end
        tests++; if (out_carry !== 1'b0) begin fails++; $display("FAIL rst_carry got %b want 0", out_carry); end
        tests++; if (out_zero !== 1'b1) begin fails++; $display("FAIL rst_zero got %b want 1", out_zero); end
        rst = 1'b0;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    endtask

    // Sends one operation into an empty pipe with no backpressure, then
    // checks the latency and the result.
    task automatic run_op(input string nm, input logic [1:0] m, input logic [15:0] d,
                          input logic [3:0] a, input logic [15:0] ed, input logic ec, input logic ez);
        int k;
        @(negedge clk);
        in_valid = 1'b1; in_mode = m; in_data = d; in_amt = a; out_ready = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL %s in_ready got %b want 1", nm, in_ready); end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        while (out_valid !== 1'b1 && k < 20) begin
            @(posedge clk); @(negedge clk); k++;
        end
        tests++; if (k !== 3) begin fails++; $display("FAIL %s latency got %0d edges want 3", nm, k); end
        tests++; if (out_data !== ed) begin fails++; $display("FAIL %s data got %h want %h", nm, out_data, ed); end
        tests++; if (out_carry !== ec) begin fails++; $display("FAIL %s carry got %b want %b", nm, out_carry, ec); end
        tests++; if (out_zero !== ez) begin fails++; $display("FAIL %s zero got %b want %b", nm, out_zero, ez); end
    endtask

    task automatic test_modes;
        run_op("lsl_8001_1",  LSL, 16'h8001, 4'd1,  16'h0002, 1'b1, 1'b0);
        run_op("lsr_8001_1",  LSR, 16'h8001, 4'd1,  16'h4000, 1'b1, 1'b0);
        run_op("asr_8000_4",  ASR, 16'h8000, 4'd4,  16'hF800, 1'b0, 1'b0);
        run_op("asr_8008_4",  ASR, 16'h8008, 4'd4,  16'hF800, 1'b1, 1'b0);
        run_op("rol_8001_4",  ROL, 16'h8001, 4'd4,  16'h0018, 1'b0, 1'b0);
        run_op("rol_1234_0",  ROL, 16'h1234, 4'd0,  16'h1234, 1'b0, 1'b0);
        run_op("lsl_8000_1",  LSL, 16'h8000, 4'd1,  16'h0000, 1'b1, 1'b1);
    endtask

    task automatic test_boundaries;
        run_op("lsl_0002_15", LSL, 16'h0002, 4'd15, 16'h0000, 1'b1, 1'b1);
        run_op("lsr_ffff_15", LSR, 16'hFFFF, 4'd15, 16'h0001, 1'b1, 1'b0);
        run_op("asr_7fff_15", ASR, 16'h7FFF, 4'd15, 16'h0000, 1'b1, 1'b1);
        run_op("rol_0001_15", ROL, 16'h0001, 4'd15, 16'h8000, 1'b0, 1'b0);
        run_op("lsl_abcd_0",  LSL, 16'hABCD, 4'd0,  16'hABCD, 1'b0, 1'b0);
        run_op("asr_c0de_0",  ASR, 16'hC0DE, 4'd0,  16'hC0DE, 1'b0, 1'b0);
    endtask

    // Streams 8 LSL ops (data i+1, amt i) while the output stalls for 10 cycles.
    task automatic test_stall;
        logic [15:0] exp_d [8];
        int idx, j, cyc, unstable;
        logic held, ai, ao, hc, hz;
        logic [15:0] hd;
        exp_d[0] = 16'h0001; exp_d[1] = 16'h0004; exp_d[2] = 16'h000C; exp_d[3] = 16'h0020;
        exp_d[4] = 16'h0050; exp_d[5] = 16'h00C0; exp_d[6] = 16'h01C0; exp_d[7] = 16'h0400;
        idx = 0; j = 0; cyc = 0; unstable = 0; held = 1'b0; hd = '0; hc = 1'b0; hz = 1'b0;
        while (j < 8 && cyc < 80) begin
            @(negedge clk);
            out_ready = (cyc >= 10);
            in_valid  = (idx < 8);
            in_mode   = LSL;
            in_data   = 16'(idx + 1);
            in_amt    = 4'(idx);
            #1;
            if (cyc == 9) begin
                tests++; if (idx !== 4) begin fails++; $display("FAIL stall_accepts got %0d want 4", idx); end
                tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_in_ready got %b want 0", in_ready); end
            end
            if (out_valid && !out_ready) begin
                if (!held) begin
                    held = 1'b1; hd = out_data; hc = out_carry; hz = out_zero;
                end else if (out_data !== hd || out_carry !== hc || out_zero !== hz) begin
                    unstable++;
                end
            end
            ai = in_valid && in_ready;
            ao = out_valid && out_ready;
            if (ao) begin
                tests++; if (out_data !== exp_d[j]) begin fails++; $display("FAIL stall_result%0d got %h want %h", j, out_data, exp_d[j]); end
                j++;
            end
            @(posedge clk);
            if (ai) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        tests++; if (j !== 8) begin fails++; $display("FAIL stall_drain_count got %0d want 8", j); end
        tests++; if (unstable !== 0) begin fails++; $display("FAIL stall_stable got %0d changes want 0", unstable); end
        tests++; if (hd !== 16'h0001) begin fails++; $display("FAIL stall_head got %h want 0001", hd); end
        repeat (5) @(posedge clk);
        @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stall_no_dup got %b want 0", out_valid); end
    endtask

    // Reset with three ops in flight: nothing survives, and the next op works.
    task automatic test_reset_flight;
        int seen;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid = 1'b1; in_mode = LSL; in_data = 16'(i + 1); in_amt = 4'd1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL flight_pre_valid got %b want 1", out_valid); end
        #1 rst = 1'b1;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flight_rst_valid got %b want 0", out_valid); end
        tests++; if (out_data !== 16'h0000) begin fails++; $display("FAIL flight_rst_data got %h want 0000", out_data); end
        tests++; if (out_zero !== 1'b1) begin fails++; $display("FAIL flight_rst_zero got %b want 1", out_zero); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL flight_in_ready got %b want 1", in_ready); end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        tests++; if (seen !== 0) begin fails++; $display("FAIL flight_ghost got %0d results want 0", seen); end
        run_op("post_rst_lsr", LSR, 16'hF0F0, 4'd4, 16'h0F0F, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset;
        test_modes;
        test_boundaries;
        test_stall;
        test_reset_flight;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout tests=%0d", tests);
        $fatal(1);
    end
endmodule
